uart_cmd_rx: RTL and testbench

UART receiver for the opposite direction of the lap-time transmitter: PC to FPGA. It deserialises 8N1 frames from the host and decodes single-ASCII-character commands into one-cycle pulses. The top-level FSM uses those pulses to arm a run, abort a run, or request a re-send of the last time. It sits beside uart_time_tx in top, sharing clk and the global reset.

---
 rtl/uart_cmd_rx.sv | 144 ++++++++++++++
 tb/tb_uart_cmd_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver that decodes single-character host commands into one-cycle pulses.
// Latency: ~2+HALF_BIT+9*CLKS_PER_BIT cycles from the start edge; no backpressure, so o_byte must be taken within one frame.
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_rx_pin,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic       o_cmd_arm,
  output logic       o_cmd_abort,
  output logic       o_cmd_query
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t          r_state;
  logic            r_rx_meta;
  logic            r_rx_s;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_byte;
  logic            r_byte_valid;
  logic            r_frame_err;
  logic            r_cmd_arm;
  logic            r_cmd_abort;
  logic            r_cmd_query;

  logic            w_is_arm;
  logic            w_is_abort;
  logic            w_is_query;

  assign w_is_arm   = (r_shift == 8'h41) || (r_shift == 8'h61);
  assign w_is_abort = (r_shift == 8'h58) || (r_shift == 8'h78);
  assign w_is_query = (r_shift == 8'h3F);

  // Synchroniser resets to the idle (high) level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx_pin;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_cmd_arm    <= 1'b0;
      r_cmd_abort  <= 1'b0;
      r_cmd_query  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_cmd_arm    <= 1'b0;
      r_cmd_abort  <= 1'b0;
      r_cmd_query  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          if (r_cnt == C_HALF_LAST) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_state <= r_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == C_BIT_LAST) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= r_rx_s;
            if (r_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == C_BIT_LAST) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_byte       <= r_shift;
              r_byte_valid <= 1'b1;
              r_cmd_arm    <= w_is_arm;
              r_cmd_abort  <= w_is_abort;
              r_cmd_query  <= w_is_query;
              r_state      <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (r_rx_s) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_byte       = r_byte;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;
  assign o_cmd_arm    = r_cmd_arm;
  assign o_cmd_abort  = r_cmd_abort;
  assign o_cmd_query  = r_cmd_query;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_uart_cmd_rx;

  localparam int CPB = 217;
  localparam int EXP_LAT = 2 + CPB / 2 + 9 * CPB;

  logic       clk;
  logic       reset_n;
  logic       i_rx_pin;
  logic [7:0] o_byte;
  logic       o_byte_valid;
  logic       o_frame_err;
  logic       o_cmd_arm;
  logic       o_cmd_abort;
  logic       o_cmd_query;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_rx_pin     (i_rx_pin),
    .o_byte       (o_byte),
    .o_byte_valid (o_byte_valid),
    .o_frame_err  (o_frame_err),
    .o_cmd_arm    (o_cmd_arm),
    .o_cmd_abort  (o_cmd_abort),
    .o_cmd_query  (o_cmd_query)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Event vector: {frame_err, byte_valid, arm, abort, query, byte}
  typedef struct {
    logic [12:0] v;
    int          t;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [7:0]  last_byte = 8'h00;
  logic [12:0] got;
  exp_t        e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n && (o_byte_valid || o_frame_err || o_cmd_arm || o_cmd_abort || o_cmd_query)) begin
      got = {o_frame_err, o_byte_valid, o_cmd_arm, o_cmd_abort, o_cmd_query, o_byte};
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output got=%h want=none at cyc=%0d", got, cyc);
      end else begin
        e = q.pop_front();
        if (got !== e.v) begin
          bad++;
          $display("FAIL event got=%h want=%h at cyc=%0d", got, e.v, cyc);
        end
        total++;
        if (cyc - e.t > 2 || e.t - cyc > 2) begin
          bad++;
          $display("FAIL latency got_cyc=%0d want_cyc=%0d(+-2)", cyc, e.t);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic [12:0] want);
    logic [12:0] now;
    now = {o_frame_err, o_byte_valid, o_cmd_arm, o_cmd_abort, o_cmd_query, o_byte};
    total++;
    if (now !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, now, want);
    end
  endtask

  // Called at posedge+1; leaves the line at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    logic [9:0] fr;
    exp_t       x;
    logic       arm, abort, query;
    arm   = (b == 8'h41) || (b == 8'h61);
    abort = (b == 8'h58) || (b == 8'h78);
    query = (b == 8'h3F);
    x.t = cyc + EXP_LAT;
    if (stop_ok) begin
      x.v = {1'b0, 1'b1, arm, abort, query, b};
      last_byte = b;
    end else begin
      x.v = {1'b1, 1'b0, 3'b000, last_byte};
    end
    q.push_back(x);
    fr = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      i_rx_pin = fr[i];
      wait_cyc(CPB);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 5000) begin
      wait_cyc(1);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout pending=%0d want=0", name, q.size());
    end
  endtask

  initial begin
    logic [7:0] pb;
    reset_n  = 1'b0;
    i_rx_pin = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_outs("reset_state", 13'h0000);
    reset_n = 1'b1;
    wait_cyc(20);
    check_outs("post_reset_idle", 13'h0000);

    // Single arm command.
    send_frame(8'h41, 1'b1);
    wait_cyc(20);
    drain("arm_41");

    // Back-to-back, no gap.
    send_frame(8'h55, 1'b1);
    send_frame(8'h3F, 1'b1);
    wait_cyc(20);
    drain("b2b");

    // Stop bit low then a 5000-cycle break: a single frame error.
    send_frame(8'h78, 1'b0);
    wait_cyc(5000);
    i_rx_pin = 1'b1;
    wait_cyc(50);
    drain("break");
    check_outs("byte_held_after_err", {5'b00000, 8'h3F});
    send_frame(8'h58, 1'b1);
    wait_cyc(20);
    drain("abort_58");

    // Short low glitch on an idle line.
    i_rx_pin = 1'b0;
    wait_cyc(50);
    i_rx_pin = 1'b1;
    wait_cyc(300);
    send_frame(8'h61, 1'b1);
    wait_cyc(20);
    drain("arm_61");

    // Reset during data bit 4 of 0x41.
    pb = 8'h41;
    i_rx_pin = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 5; i++) begin
      i_rx_pin = pb[i];
      wait_cyc(i < 4 ? CPB : 100);
    end
    check_outs("before_mid_reset", {5'b00000, 8'h61});
    reset_n = 1'b0;
    #1;
    check_outs("mid_frame_reset", 13'h0000);
    last_byte = 8'h00;
    i_rx_pin = 1'b1;
    wait_cyc(10);
    reset_n = 1'b1;
    wait_cyc(CPB * 6);
    check_outs("after_mid_reset", 13'h0000);
    send_frame(8'h3F, 1'b1);
    wait_cyc(20);
    drain("query_after_reset");

    // Long reset with idle line, then quiet period.
    reset_n = 1'b0;
    wait_cyc(100);
    check_outs("long_reset", 13'h0000);
    reset_n = 1'b1;
    wait_cyc(10000);
    check_outs("quiet_after_reset", 13'h0000);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL final_queue got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
